uart_cfg: RTL and testbench
===========================

# uart_cfg

Runtime-configurable UART with FIFO buffering on both directions, parity generation/checking, selectable stop bits, per-character error tagging and a hardware echo mode. It replaces the fixed-format 8N1 UART between the host serial pins and the image-processing core. The core reads and writes whole characters through FIFO handshakes. In echo mode, received characters are forwarded to the transmitter with no core involvement.

## Interface
Parameters:
- DBIT, 8: data bits per character (5–8)
- FIFO_W, 5: FIFO address bits; each FIFO holds 2^FIFO_W entries
- DVSR_BIT, 11: width of the runtime baud divisor

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dvsr  in  DVSR_BIT  clock cycles per oversample tick (baud = f_clk/(16·dvsr)); values <2 treated as 2
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- stop2  in  1  0: one stop bit (16 ticks), 1: two stop bits (32 ticks)
- echo  in  1  1: rx FIFO head is moved to the tx FIFO automatically; rd_uart/wr_uart ignored
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output
- rd_uart  in  1  pop rx FIFO head
- wr_uart  in  1  push w_data into tx FIFO
- w_data  in  DBIT  character to transmit
- r_data  out  DBIT  rx FIFO head (first-word fall-through)
- r_par_err  out  1  parity error tag of the head entry
- r_frm_err  out  1  framing error tag of the head entry
- rx_empty, rx_full, tx_empty, tx_full  out  1  FIFO status
- rx_count, tx_count  out  FIFO_W+1  FIFO occupancy
- overrun  out  1  sticky: a character arrived while the rx FIFO was full
- clr_err  in  1  clears overrun

## Operation
- Baud generator: free-running counter 0..dvsr-1; a 1-cycle tick at count dvsr-1. A dvsr change takes effect when the counter next wraps.
- rx passes through a 2-flop synchronizer before the receiver.
- Receiver FSM:
  - idle: a low input moves to start.
  - start: after 7 ticks, re-sample. Still low → data, else → idle (glitch).
  - data: samples DBIT bits LSB first, 16 ticks apart.
  - parity (only when enabled): one bit, 16 ticks after the last data bit.
  - stop: the first stop bit is sampled 16 ticks after the previous bit. A 0 sets the frame error. A second stop bit is timed but not checked.
  - done: 1-cycle push of {frm_err, par_err, data} into the rx FIFO (width DBIT+2). If the FIFO is full, the character is dropped and overrun is set.
  - parity_mode and stop2 are latched at start-bit detection for both rx and tx.
- Transmitter FSM:
  - idle (tx=1) → start when the tx FIFO is non-empty.
  - start (16 ticks, tx=0) → data (DBIT bits LSB first, 16 ticks each) → parity (if enabled) → stop (16 or 32 ticks, tx=1).
  - The tx FIFO is popped in the cycle the stop state ends. Back-to-back characters leave no idle gap.
- Parity: even makes the count of ones in data+parity even; odd makes it odd.
- FIFOs:
  - Circular, wrap-around pointers.
  - A write when full is ignored; a read when empty is ignored.
  - Simultaneous read+write when full: both are performed and the count is unchanged.
  - Simultaneous read+write when empty: write only.
- Echo: in any cycle with rx non-empty and tx not full, pop rx and push its data into tx. Error tags are discarded. Core rd_uart/wr_uart are ignored while echo=1.
- overrun clears on clr_err. If an overrun event and clr_err occur in the same cycle, the set wins.

## Timing
- Reset values:
  - tx=1, FIFOs empty (rx_empty=tx_empty=1, full=0, counts=0).
  - r_data=0, r_par_err=0, r_frm_err=0, overrun=0.
  - Both FSMs idle; baud counter 0.
- Reset mid-frame: tx returns high the cycle after reset is sampled; partial characters are discarded.
- Frame length = (1+DBIT+P+S)·16·dvsr cycles, where P = 1 if parity is enabled and S = 1 or 2.
- rx latency: FIFO push follows the first stop-bit sample by 1 cycle; rx_empty falls the cycle after the push.
- wr_uart to tx falling: ≤ 2 cycles plus up to one tick period.
- All flags and counts are registered and update the cycle after the causing event.

## Test plan
- dvsr=4, 8N1, core writes 0xA5 → tx shows 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; tx_count 1→0 after 640 cycles.
- Wire tx→rx, even parity, stop2=1, write 0x00,0xFF,0x3C → read back the same three bytes; r_par_err=0, r_frm_err=0.
- Inject 0x41 with a flipped parity bit (odd mode) → r_data=0x41, r_par_err=1. Inject 0x42 with stop=0 → r_frm_err=1.
- FIFO_W=2, send 5 characters without reading → rx_count=4, rx_full=1, overrun=1, and the head is the first character; clr_err → overrun=0.
- echo=1, send 0x10..0x13 on rx → the same 4 characters appear on tx in order; rd_uart pulses have no effect.
- Assert reset mid-character on tx and rx → tx=1 the next cycle, counts 0, and the next complete frame is received correctly.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART (5-8 data bits, none/even/odd parity, 1/2 stop) with rx/tx FIFOs and echo.
// Latency: rx FIFO push 1 cycle after the first stop-bit sample; tx starts on the first baud tick after the tx FIFO goes non-empty.
// Backpressure: tx_full stalls the core (writes ignored); rx_full drops incoming characters and sets sticky overrun.

module uart_fifo #(
    parameter int W  = 10,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    // Circular buffer with first-word fall-through head and registered status.
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_n;
    logic          wr_en;
    logic          rd_en;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;

    // Empty FIFO presents zero so the head outputs have a defined reset value.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Occupancy after this cycle's accepted read/write.
    always_comb begin
        count_n = count;
        case ({wr_en, rd_en})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == (AW+1)'(DEPTH));
        end
    end
endmodule

module uart_cfg #(
    parameter int DBIT     = 8,
    parameter int FIFO_W   = 5,
    parameter int DVSR_BIT = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                echo,
    input  logic                rx,
    output logic                tx,
    input  logic                rd_uart,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic [DBIT-1:0]     r_data,
    output logic                r_par_err,
    output logic                r_frm_err,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                tx_empty,
    output logic                tx_full,
    output logic [FIFO_W:0]     rx_count,
    output logic [FIFO_W:0]     tx_count,
    output logic                overrun,
    input  logic                clr_err
);
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_DONE, R_STOP2
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    // ---------------- baud generator ----------------
    logic [DVSR_BIT-1:0] baud_cnt;
    logic [DVSR_BIT-1:0] baud_lim;
    logic [DVSR_BIT-1:0] dvsr_m1;
    logic                tick;

    // Divisors below 2 are clamped to 2 so a tick never fires every cycle.
    assign dvsr_m1 = (dvsr < DVSR_BIT'(2)) ? DVSR_BIT'(1) : dvsr - DVSR_BIT'(1);
    assign tick    = (baud_cnt == baud_lim);

    // Free-running tick counter; a new divisor is adopted only at wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            baud_lim <= dvsr_m1;
        end else if (tick) begin
            baud_cnt <= '0;
            baud_lim <= dvsr_m1;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // ---------------- rx synchronizer ----------------
    logic rx_meta;
    logic rx_sync;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t       rx_st, rx_st_n;
    logic [3:0]      rx_s, rx_s_n;
    logic [2:0]      rx_n, rx_n_n;
    logic [DBIT-1:0] rx_b, rx_b_n;
    logic            rx_par_en, rx_par_en_n;
    logic            rx_odd, rx_odd_n;
    logic            rx_stop2, rx_stop2_n;
    logic            rx_perr, rx_perr_n;
    logic            rx_ferr, rx_ferr_n;
    logic            rx_push;

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st     <= R_IDLE;
            rx_s      <= '0;
            rx_n      <= '0;
            rx_b      <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            rx_stop2  <= 1'b0;
            rx_perr   <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_st     <= rx_st_n;
            rx_s      <= rx_s_n;
            rx_n      <= rx_n_n;
            rx_b      <= rx_b_n;
            rx_par_en <= rx_par_en_n;
            rx_odd    <= rx_odd_n;
            rx_stop2  <= rx_stop2_n;
            rx_perr   <= rx_perr_n;
            rx_ferr   <= rx_ferr_n;
        end
    end

    // Receiver next state: mid-bit sampling on the 16x oversample tick.
    always_comb begin
        rx_st_n     = rx_st;
        rx_s_n      = rx_s;
        rx_n_n      = rx_n;
        rx_b_n      = rx_b;
        rx_par_en_n = rx_par_en;
        rx_odd_n    = rx_odd;
        rx_stop2_n  = rx_stop2;
        rx_perr_n   = rx_perr;
        rx_ferr_n   = rx_ferr;
        rx_push     = 1'b0;
        case (rx_st)
            R_IDLE: begin
                if (!rx_sync) begin
                    rx_st_n     = R_START;
                    rx_s_n      = '0;
                    rx_par_en_n = ^parity_mode;
                    rx_odd_n    = (parity_mode == 2'b10);
                    rx_stop2_n  = stop2;
                    rx_perr_n   = 1'b0;
                    rx_ferr_n   = 1'b0;
                end
            end
            R_START: begin
                if (tick) begin
                    if (rx_s == 4'd7) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!rx_sync) begin
                            rx_st_n = R_DATA;
                            rx_s_n  = '0;
                            rx_n_n  = '0;
                        end else begin
                            rx_st_n = R_IDLE;
                        end
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n = '0;
                        rx_b_n = {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == 3'(DBIT-1)) begin
                            rx_st_n = rx_par_en ? R_PAR : R_STOP;
                        end else begin
                            rx_n_n = rx_n + 3'd1;
                        end
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            R_PAR: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n    = '0;
                        rx_perr_n = (^rx_b) ^ rx_sync ^ rx_odd;
                        rx_st_n   = R_STOP;
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n    = '0;
                        rx_ferr_n = !rx_sync;
                        rx_st_n   = R_DONE;
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            R_DONE: begin
                rx_push = 1'b1;
                rx_s_n  = '0;
                rx_st_n = rx_stop2 ? R_STOP2 : R_IDLE;
            end
            R_STOP2: begin
                // Second stop bit is only timed so the next start edge is not mistaken early.
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_st_n = R_IDLE;
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            default: rx_st_n = R_IDLE;
        endcase
    end

    // ---------------- FIFOs and echo path ----------------
    logic [DBIT+1:0] rx_head;
    logic [DBIT-1:0] tx_head;
    logic [DBIT-1:0] tx_wdata;
    logic            rx_rd;
    logic            tx_wr;
    logic            tx_pop;
    logic            echo_mv;
    logic            rx_drop;

    assign echo_mv  = echo && !rx_empty && !tx_full;
    assign rx_rd    = echo ? echo_mv : rd_uart;
    assign tx_wr    = echo ? echo_mv : wr_uart;
    assign tx_wdata = echo ? rx_head[DBIT-1:0] : w_data;
    assign rx_drop  = rx_push && rx_full && !rx_rd;

    assign r_data    = rx_head[DBIT-1:0];
    assign r_par_err = rx_head[DBIT];
    assign r_frm_err = rx_head[DBIT+1];

    uart_fifo #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_push),
        .wdata ({rx_ferr, rx_perr, rx_b}),
        .rd    (rx_rd),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    uart_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_wdata),
        .rd    (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (rx_drop) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t       tx_st, tx_st_n;
    logic [4:0]      tx_s, tx_s_n;
    logic [2:0]      tx_n, tx_n_n;
    logic [DBIT-1:0] tx_b, tx_b_n;
    logic            tx_pbit, tx_pbit_n;
    logic            tx_par_en, tx_par_en_n;
    logic            tx_odd, tx_odd_n;
    logic            tx_stop2, tx_stop2_n;
    logic            tx_reg, tx_next;

    assign tx = tx_reg;

    // Transmitter state register; tx line is registered and idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st     <= T_IDLE;
            tx_s      <= '0;
            tx_n      <= '0;
            tx_b      <= '0;
            tx_pbit   <= 1'b0;
            tx_par_en <= 1'b0;
            tx_odd    <= 1'b0;
            tx_stop2  <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            tx_st     <= tx_st_n;
            tx_s      <= tx_s_n;
            tx_n      <= tx_n_n;
            tx_b      <= tx_b_n;
            tx_pbit   <= tx_pbit_n;
            tx_par_en <= tx_par_en_n;
            tx_odd    <= tx_odd_n;
            tx_stop2  <= tx_stop2_n;
            tx_reg    <= tx_next;
        end
    end

    // Transmitter next state; frames start on a tick so every bit is exactly 16 ticks.
    always_comb begin
        tx_st_n     = tx_st;
        tx_s_n      = tx_s;
        tx_n_n      = tx_n;
        tx_b_n      = tx_b;
        tx_pbit_n   = tx_pbit;
        tx_par_en_n = tx_par_en;
        tx_odd_n    = tx_odd;
        tx_stop2_n  = tx_stop2;
        tx_pop      = 1'b0;
        tx_next     = 1'b1;
        case (tx_st)
            T_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_st_n     = T_START;
                    tx_s_n      = '0;
                    tx_par_en_n = ^parity_mode;
                    tx_odd_n    = (parity_mode == 2'b10);
                    tx_stop2_n  = stop2;
                end
            end
            T_START: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        // Head is loaded late so a back-to-back pop has settled by now.
                        tx_st_n   = T_DATA;
                        tx_s_n    = '0;
                        tx_n_n    = '0;
                        tx_b_n    = tx_head;
                        tx_pbit_n = (^tx_head) ^ tx_odd;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            T_DATA: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n = '0;
                        tx_b_n = tx_b >> 1;
                        if (tx_n == 3'(DBIT-1)) begin
                            tx_st_n = tx_par_en ? T_PAR : T_STOP;
                        end else begin
                            tx_n_n = tx_n + 3'd1;
                        end
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            T_PAR: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n  = '0;
                        tx_st_n = T_STOP;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            T_STOP: begin
                if (tick) begin
                    if (tx_s == (tx_stop2 ? 5'd31 : 5'd15)) begin
                        tx_pop = 1'b1;
                        tx_s_n = '0;
                        // Another queued character follows with no idle gap.
                        if (tx_count > (FIFO_W+1)'(1)) begin
                            tx_st_n     = T_START;
                            tx_par_en_n = ^parity_mode;
                            tx_odd_n    = (parity_mode == 2'b10);
                            tx_stop2_n  = stop2;
                        end else begin
                            tx_st_n = T_IDLE;
                        end
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            default: tx_st_n = T_IDLE;
        endcase
        case (tx_st_n)
            T_START: tx_next = 1'b0;
            T_DATA:  tx_next = tx_b_n[0];
            T_PAR:   tx_next = tx_pbit_n;
            default: tx_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: 8-bit characters, 4-entry FIFOs, dvsr=4 (64 cycles per bit).
// Serial frames are driven and decoded by the bench at bit-middle sample points.
// Expected characters/bits are queued when stimulus is driven and compared as the DUT produces them.

module tb_uart_cfg;
    localparam int DBIT     = 8;
    localparam int FIFO_W   = 2;
    localparam int DVSR_BIT = 11;
    localparam int BITC     = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [DVSR_BIT-1:0] dvsr;
    logic [1:0]          parity_mode;
    logic                stop2;
    logic                echo;
    logic                rx_in;
    logic                tx;
    logic                rd_uart;
    logic                wr_uart;
    logic [DBIT-1:0]     w_data;
    logic [DBIT-1:0]     r_data;
    logic                r_par_err;
    logic                r_frm_err;
    logic                rx_empty, rx_full, tx_empty, tx_full;
    logic [FIFO_W:0]     rx_count, tx_count;
    logic                overrun;
    logic                clr_err;
    logic                loop_en;
    logic                rx_drv;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];
    logic [7:0] byte_q[$];
    logic       bit_q[$];

    assign rx_in = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_cfg #(.DBIT(DBIT), .FIFO_W(FIFO_W), .DVSR_BIT(DVSR_BIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .dvsr        (dvsr),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .echo        (echo),
        .rx          (rx_in),
        .tx          (tx),
        .rd_uart     (rd_uart),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .r_data      (r_data),
        .r_par_err   (r_par_err),
        .r_frm_err   (r_frm_err),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .tx_empty    (tx_empty),
        .tx_full     (tx_full),
        .rx_count    (rx_count),
        .tx_count    (tx_count),
        .overrun     (overrun),
        .clr_err     (clr_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one serial frame on rx_drv; flip inverts the parity bit, stop_v is the first stop bit value.
    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic odd,
                           input logic flip, input logic stop_v, input logic two_stop);
        rx_drv = 1'b0;
        cyc(BITC);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cyc(BITC);
        end
        if (par_en) begin
            rx_drv = (^d) ^ odd ^ flip;
            cyc(BITC);
        end
        rx_drv = stop_v;
        cyc(BITC);
        rx_drv = 1'b1;
        if (two_stop) cyc(BITC);
    endtask

    task automatic pop_rx(output logic [9:0] got);
        got = {r_frm_err, r_par_err, r_data};
        rd_uart = 1'b1;
        cyc(1);
        rd_uart = 1'b0;
    endtask

    task automatic wait_rx(input int want, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (int'(rx_count) >= want) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_tx_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dvsr = 11'd4; parity_mode = 2'b00; stop2 = 1'b0; echo = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0; rd_uart = 1'b0; wr_uart = 1'b0; clr_err = 1'b0;
        w_data = '0;
        cyc(4);
        reset = 1'b0;
        cyc(1);
        n_cmp++;
        if ({tx, rx_empty, tx_empty, rx_full, tx_full, overrun} !== 6'b111000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 111000", {tx, rx_empty, tx_empty, rx_full, tx_full, overrun});
        end
        n_cmp++;
        if (rx_count !== 3'd0 || tx_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_counts: got rx=%0d tx=%0d expected 0/0", rx_count, tx_count);
        end
        n_cmp++;
        if ({r_frm_err, r_par_err, r_data} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_head: got %h expected 000", {r_frm_err, r_par_err, r_data});
        end
    endtask

    task automatic test_tx_8n1();
        logic [7:0] d;
        logic       e;
        bit         ok;
        d = 8'hA5;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
        bit_q.push_back(1'b1);
        w_data = d; wr_uart = 1'b1;
        cyc(1);
        wr_uart = 1'b0;
        n_cmp++;
        if (tx_count !== 3'd1) begin
            n_err++;
            $display("FAIL tx_count_after_wr: got %0d expected 1", tx_count);
        end
        wait_tx_low(40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL tx_start_timeout: got no start bit expected start within 40 cycles");
        end else begin
            cyc(32);
            for (int i = 0; i < 10; i++) begin
                e = bit_q.pop_front();
                n_cmp++;
                if (tx !== e) begin
                    n_err++;
                    $display("FAIL tx_bit%0d: got %b expected %b", i, tx, e);
                end
                if (i == 0) begin
                    cyc(31);
                    n_cmp++;
                    if (tx !== 1'b0) begin
                        n_err++;
                        $display("FAIL start_len_lo: got %b expected 0 at cycle 63", tx);
                    end
                    cyc(1);
                    n_cmp++;
                    if (tx !== 1'b1) begin
                        n_err++;
                        $display("FAIL start_len_hi: got %b expected 1 at cycle 64", tx);
                    end
                    cyc(32);
                end else if (i < 9) begin
                    cyc(BITC);
                end
            end
            cyc(22);
            n_cmp++;
            if (tx_count !== 3'd1) begin
                n_err++;
                $display("FAIL tx_count_630: got %0d expected 1", tx_count);
            end
            cyc(20);
            n_cmp++;
            if (tx_count !== 3'd0 || tx !== 1'b1) begin
                n_err++;
                $display("FAIL tx_count_650: got count=%0d tx=%b expected 0/1", tx_count, tx);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] vals [3];
        logic [9:0] got, e;
        bit         ok;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
        parity_mode = 2'b01; stop2 = 1'b1; loop_en = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            w_data = vals[i]; wr_uart = 1'b1;
            exp_q.push_back({2'b00, vals[i]});
            cyc(1);
        end
        wr_uart = 1'b0;
        wait_rx(3, 4000, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL loopback_timeout: got rx_count=%0d expected 3", rx_count);
        end
        for (int i = 0; i < 3; i++) begin
            pop_rx(got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL loopback_char%0d: got %h expected %h", i, got, e);
            end
        end
        loop_en = 1'b0;
        cyc(200);
    endtask

    task automatic test_parity_err();
        logic [9:0] got, e;
        bit         ok;
        parity_mode = 2'b10; stop2 = 1'b0;
        exp_q.push_back({2'b01, 8'h41});
        send_rx(8'h41, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({2'b10, 8'h42});
        send_rx(8'h42, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(800);
        wait_rx(2, 100, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL err_timeout: got rx_count=%0d expected >=2", rx_count);
        end
        for (int i = 0; i < 2; i++) begin
            pop_rx(got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL err_char%0d: got %h expected %h", i, got, e);
            end
        end
        // A low stop bit may be re-detected as a start; discard whatever that produced.
        for (int k = 0; k < 4 && !rx_empty; k++) pop_rx(got);
        parity_mode = 2'b00;
    endtask

    task automatic test_overrun();
        logic [9:0] got, e;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
            send_rx(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(20);
        n_cmp++;
        if (rx_count !== 3'd4 || rx_full !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_full: got count=%0d full=%b expected 4/1", rx_count, rx_full);
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set: got %b expected 1", overrun);
        end
        n_cmp++;
        if (r_data !== 8'h11) begin
            n_err++;
            $display("FAIL ovr_head: got %h expected 11", r_data);
        end
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            pop_rx(got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL ovr_char%0d: got %h expected %h", i, got, e);
            end
        end
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_drained: got rx_empty=%b expected 1", rx_empty);
        end
    endtask

    task automatic test_echo();
        echo = 1'b1;
        cyc(2);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    byte_q.push_back(8'h10 + 8'(i));
                    send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
            begin
                repeat (40) begin
                    cyc(50);
                    rd_uart = 1'b1;
                    cyc(1);
                    rd_uart = 1'b0;
                end
            end
            begin
                logic [7:0] b, e;
                bit         ok;
                for (int c = 0; c < 4; c++) begin
                    wait_tx_low(3000, ok);
                    n_cmp++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL echo_timeout%0d: got no start bit expected one", c);
                        break;
                    end
                    cyc(32);
                    for (int i = 0; i < 8; i++) begin
                        cyc(BITC);
                        b[i] = tx;
                    end
                    cyc(BITC);
                    e = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
                    n_cmp++;
                    if (b !== e || tx !== 1'b1) begin
                        n_err++;
                        $display("FAIL echo_char%0d: got %h stop=%b expected %h stop=1", c, b, tx, e);
                    end
                end
            end
        join
        cyc(100);
        n_cmp++;
        if (rx_count !== 3'd0 || tx_count !== 3'd0) begin
            n_err++;
            $display("FAIL echo_counts: got rx=%0d tx=%0d expected 0/0", rx_count, tx_count);
        end
        echo = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        bit         ok;
        for (int i = 0; i < 2; i++) begin
            w_data = 8'h00; wr_uart = 1'b1;
            cyc(1);
        end
        wr_uart = 1'b0;
        rx_drv = 1'b0;
        cyc(BITC);
        rx_drv = 1'b1;
        cyc(200);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre_tx: got %b expected 0", tx);
        end
        reset = 1'b1;
        cyc(1);
        n_cmp++;
        if (tx !== 1'b1 || rx_count !== 3'd0 || tx_count !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset: got tx=%b rx=%0d txc=%0d expected 1/0/0", tx, rx_count, tx_count);
        end
        reset = 1'b0;
        cyc(1000);
        n_cmp++;
        if (tx !== 1'b1 || rx_empty !== 1'b1) begin
            n_err++;
            $display("FAIL mid_quiet: got tx=%b rx_empty=%b expected 1/1", tx, rx_empty);
        end
        exp_q.push_back({2'b00, 8'h5A});
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_rx(1, 100, ok);
        cyc(2);
        n_cmp++;
        if (!ok || rx_count !== 3'd1) begin
            n_err++;
            $display("FAIL mid_rx_count: got %0d expected 1", rx_count);
        end
        pop_rx(got);
        n_cmp++;
        if (got !== exp_q[0]) begin
            n_err++;
            $display("FAIL mid_rx_char: got %h expected %h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_parity_err();
        test_overrun();
        test_echo();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
